// File: rtl/wb_stage.sv
// Writeback stage: merges ALU results with buffered, formatted LSU load results into one register-file write per cycle.
// Optional forwarding ports from the registered write outputs are enabled by defining WB_FWD_EN.
module wb_stage #(
  parameter int XLEN       = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            alu_valid,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  output logic            alu_stall,
  input  logic            lsu_valid,
  output logic            lsu_ready,
  input  logic [4:0]      lsu_rd,
  input  logic [2:0]      lsu_funct3,
  input  logic [1:0]      lsu_byte_off,
  input  logic [XLEN-1:0] lsu_rdata,
  output logic            is_write,
  output logic [4:0]      wb_addr,
  output logic [XLEN-1:0] wb_data
`ifdef WB_FWD_EN
  ,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  output logic            fwd_rs1_hit,
  output logic            fwd_rs2_hit,
  output logic [XLEN-1:0] fwd_data
`endif
);

  localparam logic [3:0] LP_STARVE_MAX = 4'(STARVE_MAX);

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_HELD  = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [4:0]      r_buf_rd;
  logic [XLEN-1:0] r_buf_data;
  logic [3:0]      r_starve_cnt;

  logic            w_held;
  logic            w_capture;
  logic            w_buf_win;
  logic            w_alu_win;
  logic [4:0]      w_wr_rd;
  logic [XLEN-1:0] w_wr_data;
  logic            w_wr_en;
  logic [7:0]      w_byte;
  logic [15:0]     w_half;
  logic [XLEN-1:0] w_fmt;

  assign w_held    = (r_state == S_HELD);
  assign lsu_ready = ~w_held & ~reset;
  assign alu_stall = w_held & (r_starve_cnt == LP_STARVE_MAX);
  assign w_capture = lsu_valid & lsu_ready;

  // Load data is formatted on the way into the buffer so the drain path is a plain mux.
  always_comb begin
    w_byte = lsu_rdata[{lsu_byte_off, 3'b000} +: 8];
    w_half = lsu_rdata[{lsu_byte_off[1], 4'b0000} +: 16];
    case (lsu_funct3)
      3'b000:  w_fmt = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_fmt = {24'd0, w_byte};
      3'b001:  w_fmt = {{16{w_half[15]}}, w_half};
      3'b101:  w_fmt = {16'd0, w_half};
      default: w_fmt = lsu_rdata;
    endcase
  end

  always_comb begin
    w_buf_win = 1'b0;
    w_alu_win = 1'b0;
    if (alu_stall) begin
      w_buf_win = 1'b1;
    end else if (alu_valid) begin
      w_alu_win = 1'b1;
    end else if (w_held) begin
      w_buf_win = 1'b1;
    end
  end

  assign w_wr_rd   = w_buf_win ? r_buf_rd : alu_rd;
  assign w_wr_data = w_buf_win ? r_buf_data : alu_data;
  assign w_wr_en   = (w_buf_win | w_alu_win) & (w_wr_rd != 5'd0);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_EMPTY: if (w_capture) w_state_next = S_HELD;
      S_HELD:  if (w_buf_win) w_state_next = S_EMPTY;
      default: w_state_next = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_buf_rd   <= 5'd0;
      r_buf_data <= '0;
    end else if (w_capture) begin
      r_buf_rd   <= lsu_rd;
      r_buf_data <= w_fmt;
    end
  end

  // Counts ALU wins over a waiting load; at the limit the load is forced through.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_starve_cnt <= 4'd0;
    end else if (w_buf_win || !w_held) begin
      r_starve_cnt <= 4'd0;
    end else if (w_alu_win && (r_starve_cnt != LP_STARVE_MAX)) begin
      r_starve_cnt <= r_starve_cnt + 4'd1;
    end
  end

  // x0 destinations are consumed but leave the address/data registers untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      is_write <= 1'b0;
      wb_addr  <= 5'd0;
      wb_data  <= '0;
    end else if (w_wr_en) begin
      is_write <= 1'b1;
      wb_addr  <= w_wr_rd;
      wb_data  <= w_wr_data;
    end else begin
      is_write <= 1'b0;
    end
  end

`ifdef WB_FWD_EN
  assign fwd_rs1_hit = ~reset & is_write & (wb_addr == rs1_addr) & (rs1_addr != 5'd0);
  assign fwd_rs2_hit = ~reset & is_write & (wb_addr == rs2_addr) & (rs2_addr != 5'd0);
  assign fwd_data    = reset ? '0 : wb_data;
`endif

endmodule
